// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and default wait-timeout for the stall controller
package pipeline_ctrl_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
// Ports: clk_i clock, rst_i sync active-high reset, inc_i count enable, cnt_o count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i)
    if (rst_i) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: merges load-use, taken-branch and data-memory wait into per-stage pipeline controls
// Ports: clk_i/rst_i clock and sync active-high reset; load_use_i, branch_taken_i hazard inputs from ID;
// mem_req_i/mem_ack_i MEM-stage access handshake; pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
// stage_write_o, memwb_bubble_o pipeline register controls; mem_enable_o memory request;
// mem_err_o sticky timeout flag; stall_cnt_o/flush_cnt_o saturating performance counters.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             stage_write_o,
  output logic             memwb_bubble_o,
  output logic             mem_enable_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);
  state_t state;
  logic [WC_W-1:0] wait_cnt;
  logic mem_on, freeze, run_ok;
  // freeze covers the miss cycle seen from RUN and every unacknowledged MEM_WAIT cycle;
  // hazard inputs are only honoured outside a freeze, so they land on the release cycle
  always_comb begin
    mem_on = !rst_i && (state == MEM_WAIT || mem_req_i);
    freeze = mem_on && !mem_ack_i;
    run_ok = !rst_i && !freeze;
    mem_enable_o = mem_on;
    pc_write_o = run_ok && (branch_taken_i || !load_use_i);
    ifid_write_o = run_ok && (branch_taken_i || !load_use_i);
    ifid_flush_o = run_ok && branch_taken_i;
    idex_bubble_o = run_ok && (branch_taken_i || load_use_i);
    stage_write_o = run_ok;
    memwb_bubble_o = freeze;
  end
  // wait_cnt holds at TIMEOUT-1 so it never wraps; the error flag is sticky anyway
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state <= freeze ? MEM_WAIT : RUN;
      wait_cnt <= (state == RUN) ? '0 : (wait_cnt == WC_MAX) ? wait_cnt : wait_cnt + 1'b1;
      if (state == MEM_WAIT && wait_cnt == WC_MAX && !mem_ack_i) mem_err_o <= 1'b1;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(!pc_write_o),
    .cnt_o(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(ifid_flush_o),
    .cnt_o(flush_cnt_o)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed stimulus, per-cycle reference model compare plus literal spot checks
module tb_pipeline_stall_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SAT = 15;
  logic clk = 1'b0;
  logic rst = 1'b1, lu = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, stage_write, memwb_bubble, mem_enable, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;
  pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .load_use_i(lu),
    .branch_taken_i(br),
    .mem_req_i(req),
    .mem_ack_i(ack),
    .pc_write_o(pc_write),
    .ifid_write_o(ifid_write),
    .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble),
    .stage_write_o(stage_write),
    .memwb_bubble_o(memwb_bubble),
    .mem_enable_o(mem_enable),
    .mem_err_o(mem_err),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // reference model: whether the pipeline is waiting on memory, how long, and event tallies
  bit m_valid = 0;
  bit m_wait = 0;
  bit m_err = 0;
  int m_waited = 0;
  int m_stall = 0;
  int m_flush = 0;
  always @(negedge clk) begin
    bit e_pc, e_ifw, e_fl, e_bub, e_sw, e_mwb, e_men, frozen;
    e_men = !rst && (m_wait || req);
    frozen = e_men && !ack;
    e_mwb = frozen;
    e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_sw = 0;
    if (!rst && !frozen) begin
      e_sw = 1;
      if (br) begin
        e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
      end else if (lu) begin
        e_bub = 1;
      end else begin
        e_pc = 1; e_ifw = 1;
      end
    end
    if (m_valid) begin
      chk("pc_write", pc_write, e_pc);
      chk("ifid_write", ifid_write, e_ifw);
      chk("ifid_flush", ifid_flush, e_fl);
      chk("idex_bubble", idex_bubble, e_bub);
      chk("stage_write", stage_write, e_sw);
      chk("memwb_bubble", memwb_bubble, e_mwb);
      chk("mem_enable", mem_enable, e_men);
      chk("mem_err", mem_err, m_err);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
    if (rst) begin
      m_valid = 1; m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_wait && m_waited == TO - 1 && !ack) m_err = 1;
      m_waited = m_wait ? m_waited + 1 : 0;
      m_wait = frozen;
      if (!e_pc && m_stall < SAT) m_stall++;
      if (e_fl && m_flush < SAT) m_flush++;
    end
  end
  task automatic cyc(input logic r, input logic l, input logic b, input logic q, input logic a);
    @(posedge clk);
    #1;
    rst = r; lu = l; br = b; req = q; ack = a;
    @(negedge clk);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_err", mem_err, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("flow_en", {pc_write, ifid_write, stage_write, ifid_flush, idex_bubble, memwb_bubble}, 6'b111000);
    end
    chk("flow_cnt", {stall_cnt, flush_cnt}, 0);
    cyc(0, 1, 0, 0, 0);
    chk("lu_pc", pc_write, 0);
    chk("lu_bub", idex_bubble, 1);
    cyc(0, 1, 1, 0, 0);
    chk("br_flush", ifid_flush, 1);
    chk("br_pc", pc_write, 1);
    cyc(0, 0, 0, 0, 0);
    chk("br_stall_cnt", stall_cnt, 1);
    chk("br_flush_cnt", flush_cnt, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("miss_frz", {mem_enable, memwb_bubble, stage_write, pc_write}, 4'b1100);
    end
    cyc(0, 0, 0, 1, 1);
    chk("miss_rel", {mem_enable, memwb_bubble, stage_write, pc_write}, 4'b1011);
    cyc(0, 0, 0, 0, 0);
    chk("miss_stall_cnt", stall_cnt, 3);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 1, 0);
      chk("lu_miss_frz", {stage_write, idex_bubble}, 2'b00);
    end
    cyc(0, 1, 0, 1, 1);
    chk("lu_miss_rel", {stage_write, pc_write, idex_bubble}, 3'b101);
    cyc(0, 0, 0, 0, 0);
    chk("lu_miss_cnt", stall_cnt, 3);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("b2b_rel", stage_write, 1);
    cyc(0, 0, 0, 1, 1);
    chk("b2b_hit", {mem_enable, stage_write, pc_write}, 3'b111);
    cyc(0, 0, 0, 1, 0);
    chk("b2b_miss", stage_write, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("to_err", mem_err, i == 6);
    end
    cyc(0, 0, 0, 1, 1);
    chk("to_rel", {mem_err, stage_write}, 2'b11);
    cyc(0, 0, 0, 0, 1);
    chk("to_stray_ack", {mem_err, mem_enable, stage_write, pc_write}, 4'b1011);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("to_clr", mem_err, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("rst_wait_men", mem_enable, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_wait_state", {mem_enable, pc_write, mem_err}, 3'b010);
    chk("rst_wait_cnt", {stall_cnt, flush_cnt}, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat_stall", stall_cnt, SAT);
    chk("sat_flush", flush_cnt, SAT);
    cyc(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
